// File: rtl/writer_pkg.sv
// Shared types and default widths for the dual-lane write-back writer.
package writer_pkg;

  localparam int unsigned DefaultWordSize = 16;
  localparam int unsigned DefaultAddrSize = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWrA  = 2'd1,
    StWrB  = 2'd2
  } state_e;

endpackage

// File: rtl/writer_fwd.sv
// Forwarding lookup over the writer's pending entries; lane B wins as the younger write.
module writer_fwd #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 5
) (
  input  logic [ADDR_SIZE-1:0] fwd_addr,
  input  logic                 a_pending,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_data,
  input  logic                 b_pending,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_data,
  output logic                 hit,
  output logic [WORD_SIZE-1:0] data
);

  logic a_match;
  logic b_match;

  always_comb begin
    a_match = a_pending && (fwd_addr == a_addr);
    b_match = b_pending && (fwd_addr == b_addr);
    hit     = a_match || b_match;
    data    = '0;
    if (b_match) begin
      data = b_data;
    end else if (a_match) begin
      data = a_data;
    end
  end

endmodule

// File: rtl/writer.sv
// Dual-lane write-back serializer: accepts an A/B result pair and drains it through
// a single memory write port, with combinational forwarding of not-yet-written entries.
module writer
  import writer_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DefaultWordSize,
  parameter int unsigned ADDR_SIZE = DefaultAddrSize
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SIZE-1:0] i_pipedata_A,
  input  logic [WORD_SIZE-1:0] i_pipedata_B,
  input  logic [ADDR_SIZE-1:0] i_pipeaddr_A,
  input  logic [ADDR_SIZE-1:0] i_pipeaddr_B,
  input  logic                 i_wren_A,
  input  logic                 i_wren_B,
  output logic [WORD_SIZE-1:0] o_wrdata,
  output logic [ADDR_SIZE-1:0] o_wraddr,
  output logic                 o_wren,
  input  logic [ADDR_SIZE-1:0] i_fwd_addr,
  output logic                 o_fwd_hit,
  output logic [WORD_SIZE-1:0] o_fwd_data,
  output logic [15:0]          o_wr_count
);

  state_e               state_q, state_d, accept_state;
  logic [WORD_SIZE-1:0] a_data_q, b_data_q;
  logic [ADDR_SIZE-1:0] a_addr_q, b_addr_q;
  logic                 a_wren_q, b_wren_q;
  logic [15:0]          count_q, count_d;
  logic                 accept;
  logic                 a_pending, b_pending;

  assign o_ready = (state_q != StWrA);
  assign accept  = i_valid && o_ready;

  // A same-address pair collapses to a single lane-B write.
  always_comb begin
    accept_state = StIdle;
    if (i_wren_A && !(i_wren_B && (i_pipeaddr_A == i_pipeaddr_B))) begin
      accept_state = StWrA;
    end else if (i_wren_B) begin
      accept_state = StWrB;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = accept_state;
      StWrA:   state_d = b_wren_q ? StWrB : StIdle;
      StWrB:   state_d = accept ? accept_state : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_wren   = 1'b0;
    o_wraddr = '0;
    o_wrdata = '0;
    unique case (state_q)
      StWrA: begin
        o_wren   = 1'b1;
        o_wraddr = a_addr_q;
        o_wrdata = a_data_q;
      end
      StWrB: begin
        o_wren   = 1'b1;
        o_wraddr = b_addr_q;
        o_wrdata = b_data_q;
      end
      default: ;
    endcase
  end

  assign count_d = (o_wren && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  assign o_wr_count = count_q;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q  <= StIdle;
      a_data_q <= '0;
      b_data_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_wren_q <= 1'b0;
      b_wren_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        a_data_q <= i_pipedata_A;
        b_data_q <= i_pipedata_B;
        a_addr_q <= i_pipeaddr_A;
        b_addr_q <= i_pipeaddr_B;
        a_wren_q <= i_wren_A;
        b_wren_q <= i_wren_B;
      end
    end
  end

  assign a_pending = (state_q == StWrA) && a_wren_q;
  assign b_pending = ((state_q == StWrA) || (state_q == StWrB)) && b_wren_q;

  writer_fwd #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_fwd (
    .fwd_addr (i_fwd_addr),
    .a_pending(a_pending),
    .a_addr   (a_addr_q),
    .a_data   (a_data_q),
    .b_pending(b_pending),
    .b_addr   (b_addr_q),
    .b_data   (b_data_q),
    .hit      (o_fwd_hit),
    .data     (o_fwd_data)
  );

endmodule

// File: doc/writer.md
WRITER -- requirements
Module: writer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 5, register-file address width.
REQ-003 SHALL have port i_CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_RST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1, write-back transaction offered.
REQ-006 SHALL have port o_ready, output, 1, transaction accepted when i_valid && o_ready at a rising edge.
REQ-007 SHALL have ports i_pipedata_A and i_pipedata_B, input, WORD_SIZE, lane A/B result data.
REQ-008 SHALL have ports i_pipeaddr_A and i_pipeaddr_B, input, ADDR_SIZE, lane A/B destination address.
REQ-009 SHALL have ports i_wren_A and i_wren_B, input, 1, lane A/B write requested.
REQ-010 SHALL have ports o_wrdata (WORD_SIZE), o_wraddr (ADDR_SIZE) and o_wren (1), all outputs, forming the single memory write port.
REQ-011 SHALL have ports i_fwd_addr (input, ADDR_SIZE), o_fwd_hit (output, 1) and o_fwd_data (output, WORD_SIZE), the forwarding lookup.
REQ-012 SHALL have port o_wr_count, output, 16, saturating count of completed writes.

Function
REQ-013 SHALL implement FSM states IDLE, WR_A and WR_B.
REQ-014 SHALL assert o_ready in IDLE and in WR_B, and deassert it in WR_A.
REQ-015 SHALL, on accept, capture both lanes' data, addresses and enables into a transaction register.
REQ-016 SHALL make the next state after accept WR_A if wren_A && !(wren_B && addr_A==addr_B), otherwise WR_B if wren_B, otherwise IDLE (empty transaction dropped).
REQ-017 SHALL go from WR_A to WR_B if the captured wren_B is set, else to IDLE.
REQ-018 SHALL go from WR_B to IDLE unless a new accept occurs at the same edge, in which case REQ-016 applies.
REQ-019 SHALL drive o_wren=1 with lane A's captured address/data in WR_A, lane B's in WR_B, and o_wren=0 in IDLE.
REQ-020 SHALL give a latency of 1 cycle from the accept edge to the first o_wren cycle, so that a dual-lane transaction occupies 2 cycles, a single-lane transaction 1 cycle, and back-to-back single-lane transactions sustain 1 write per cycle.
REQ-021 SHALL, when both lanes target the same address, write lane B only, once.
REQ-022 SHALL treat entries as pending until their write cycle completes: A in WR_A; B in WR_A (if wren_B) and in WR_B.
REQ-023 SHALL make the forwarding path combinational: o_fwd_hit=1 when i_fwd_addr matches a pending entry, with o_fwd_data from B if B matches, else from A; when there is no hit, o_fwd_hit=0 and o_fwd_data=0.
REQ-024 SHALL increment o_wr_count on each o_wren cycle and hold it at 16'hFFFF once reached.
REQ-025 SHALL ignore i_valid while o_ready=0, holding all captured values stable.

Reset
REQ-026 SHALL, while i_RST=0, force state IDLE, o_wren=0, o_wraddr=0, o_wrdata=0, o_wr_count=0, transaction register cleared, and o_fwd_hit=0, without waiting for a clock edge.
REQ-027 SHALL, on reset mid-transaction, discard the pending writes and perform no write after release.
REQ-028 SHALL accept its first transaction at the first rising edge after i_RST rises with i_valid=1.

Structure
REQ-029 SHALL place the state enumeration and the WORD_SIZE/ADDR_SIZE defaults in the shared package writer_pkg.
REQ-030 SHALL place the pending-entry address compare and select in one sub-module, writer_fwd, with the FSM and registers kept in writer.

Verification
REQ-031 SHALL cover a dual lane: A=(3,16'h1111), B=(7,16'h2222), both enabled -> o_wren on cycles 1 and 2 with (3,1111) then (7,2222), o_ready low in cycle 1, o_wr_count=2.
REQ-032 SHALL cover a same-address collision: A=(5,AAAA), B=(5,BBBB) -> exactly one write (5,BBBB), o_wr_count=1.
REQ-033 SHALL cover back-to-back single-lane transactions: i_valid held for 4 cycles, B only, addresses 0..3 -> 4 consecutive o_wren cycles, o_ready always high.
REQ-034 SHALL cover forwarding: in WR_A with A=(9,0x00C3) and B=(9 disabled), i_fwd_addr=9 -> o_fwd_hit=1, o_fwd_data=00C3; the cycle after, o_fwd_hit=0.
REQ-035 SHALL cover reset mid-operation: i_RST low asynchronously during WR_A -> o_wren=0 immediately, and no write of lane B after release.
REQ-036 SHALL cover the saturating counter: preload via 65535 writes, then 3 more -> o_wr_count stays FFFF.
